// File: rtl/alu_exec_ctrl.sv
// Four-phase instruction sequencer (IDLE/READ/EXEC/WB) between a register file and a combinational ALU.
// Optional Z/N status flags are built when ALU_EXEC_FLAGS_EN is defined.
module alu_exec_ctrl #(
   parameter int unsigned MULDIV_WAIT = 2
) (
   input  logic       clk,
   input  logic       rst,
   // start/busy handshake: start is a request that is only sampled while busy is low
   // (IDLE); an accepted request raises busy on the next cycle and done pulses for one
   // cycle when the instruction retires. Requests seen while busy is high are dropped.
   input  logic       start,
   input  logic [7:0] instruct,
   input  logic [7:0] address,
   output logic       busy,
   output logic       done,
   output logic [2:0] rf_rd_addr1,
   output logic [2:0] rf_rd_addr2,
   input  logic [7:0] rf_rd_data1,
   input  logic [7:0] rf_rd_data2,
   output logic [7:0] alu_instruct,
   output logic [7:0] alu_address,
   output logic [7:0] alu_data1,
   output logic [7:0] alu_data2,
   input  logic [7:0] alu_ans,
   output logic       rf_we,
   output logic [3:0] rf_wr_sel,
   output logic [7:0] rf_wr_data,
   output logic [7:0] result,
   output logic [1:0] fsm_state
`ifdef ALU_EXEC_FLAGS_EN
   ,
   output logic       flag_z,
   output logic       flag_n
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] EXEC = 2'd2;
   localparam logic [1:0] WB   = 2'd3;

   localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_WAIT);

   logic [1:0] state;
   logic [7:0] instr_q;
   logic [7:0] addr_q;
   logic [3:0] wait_cnt;
   logic       is_muldiv;
   logic       is_nop;
   logic       exec_last;
   logic [3:0] dest_onehot;

   assign is_muldiv = (instr_q[3:0] == 4'd3) || (instr_q[3:0] == 4'd4);
   assign is_nop    = (instr_q[3:0] == 4'd0);
   assign exec_last = (state == EXEC) && (wait_cnt == 4'd0);

   always_comb begin
      dest_onehot = 4'b0000;
      case (addr_q[1:0])
         2'b00:   dest_onehot = 4'b0001;
         2'b01:   dest_onehot = 4'b0010;
         2'b10:   dest_onehot = 4'b0100;
         default: dest_onehot = 4'b1000;
      endcase
   end

   assign busy      = (state != IDLE);
   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         instr_q      <= 8'h00;
         addr_q       <= 8'h00;
         wait_cnt     <= 4'd0;
         rf_rd_addr1  <= 3'd0;
         rf_rd_addr2  <= 3'd0;
         alu_instruct <= 8'h00;
         alu_address  <= 8'h00;
         alu_data1    <= 8'h00;
         alu_data2    <= 8'h00;
         done         <= 1'b0;
         rf_we        <= 1'b0;
         rf_wr_sel    <= 4'b0000;
         rf_wr_data   <= 8'h00;
         result       <= 8'h00;
      end else begin
         // strobes are only ever high for the single WB cycle
         done      <= 1'b0;
         rf_we     <= 1'b0;
         rf_wr_sel <= 4'b0000;
         case (state)
            IDLE: begin
               if (start) begin
                  instr_q     <= instruct;
                  addr_q      <= address;
                  rf_rd_addr1 <= address[7:5];
                  rf_rd_addr2 <= address[4:2];
                  state       <= READ;
               end
            end
            READ: begin
               alu_instruct <= instr_q;
               alu_address  <= addr_q;
               alu_data1    <= rf_rd_data1;
               alu_data2    <= rf_rd_data2;
               wait_cnt     <= is_muldiv ? WAIT_LOAD : 4'd0;
               state        <= EXEC;
            end
            EXEC: begin
               if (exec_last) begin
                  done      <= 1'b1;
                  rf_wr_sel <= dest_onehot;
                  if (!is_nop) begin
                     rf_we      <= 1'b1;
                     rf_wr_data <= alu_ans;
                     result     <= alu_ans;
                  end
                  state <= WB;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ALU_EXEC_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (exec_last && !is_nop) begin
         flag_z <= (alu_ans == 8'h00);
         flag_n <= alu_ans[7];
      end
   end
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: register-file and ALU models, vector table with a result
// scoreboard, plus hand sequences for busy-start, held start, reset abort and flags.
module tb_alu_exec_ctrl;

   localparam int unsigned MULDIV_WAIT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] instruct = 8'h00;
   logic [7:0] address = 8'h00;
   logic       busy, done, rf_we;
   logic [2:0] rf_rd_addr1, rf_rd_addr2;
   logic [7:0] rf_rd_data1, rf_rd_data2;
   logic [7:0] alu_instruct, alu_address, alu_data1, alu_data2, alu_ans;
   logic [3:0] rf_wr_sel;
   logic [7:0] rf_wr_data, result;
   logic [1:0] fsm_state;
`ifdef ALU_EXEC_FLAGS_EN
   logic       flag_z, flag_n;
`endif

   logic [7:0]  rf [8];
   logic [12:0] exp_q [$];
   int          n_cmp = 0;
   int          n_err = 0;

   typedef struct {
      logic [7:0] ins;
      logic [7:0] adr;
      logic [7:0] d1;
      logic [7:0] d2;
      logic       exp_we;
      logic [3:0] exp_sel;
      logic [7:0] exp_res;
      int         lat;
   } vec_t;

   vec_t vecs [10];

   alu_exec_ctrl #(.MULDIV_WAIT(MULDIV_WAIT)) dut (
      .clk(clk), .rst(rst), .start(start), .instruct(instruct), .address(address),
      .busy(busy), .done(done), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .alu_instruct(alu_instruct), .alu_address(alu_address),
      .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ans(alu_ans),
      .rf_we(rf_we), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data), .result(result),
      .fsm_state(fsm_state)
`ifdef ALU_EXEC_FLAGS_EN
      , .flag_z(flag_z), .flag_n(flag_n)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   assign rf_rd_data1 = rf[rf_rd_addr1];
   assign rf_rd_data2 = rf[rf_rd_addr2];

   always_comb begin
      case (alu_instruct[3:0])
         4'd1:    alu_ans = alu_data1 + alu_data2;
         4'd2:    alu_ans = alu_data1 - alu_data2;
         4'd3:    alu_ans = 8'(alu_data1 * alu_data2);
         4'd4:    alu_ans = (alu_data2 == 8'h00) ? 8'hFF : alu_data1 / alu_data2;
         4'd5:    alu_ans = alu_data1 & alu_data2;
         4'd6:    alu_ans = alu_data1 | alu_data2;
         4'd7:    alu_ans = alu_data1 ^ alu_data2;
         default: alu_ans = alu_data1;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver: one instruction, optional start pokes during READ/EXEC
   task automatic run_instr(input vec_t v, input bit poke);
      int cyc, busy_cyc, we_cnt, done_cnt, extra_done;
      logic [12:0] got, expv;
      rf[v.adr[7:5]] = v.d1;
      rf[v.adr[4:2]] = v.d2;
      @(negedge clk);
      start    = 1'b1;
      instruct = v.ins;
      address  = v.adr;
      exp_q.push_back({v.exp_we, v.exp_sel, v.exp_res});
      @(posedge clk);
      #1;
      start    = 1'b0;
      instruct = 8'($urandom);
      address  = 8'($urandom);
      cyc = 0; busy_cyc = 0; we_cnt = 0; done_cnt = 0;
      while (done_cnt == 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cyc++;
         if (rf_we) we_cnt++;
         if (poke) start = (cyc <= 2);
         if (done) begin
            done_cnt++;
            check("latency", cyc, v.lat);
            expv = exp_q.pop_front();
            got  = {rf_we, (rf_we ? rf_wr_sel : 4'b0000), result};
            check("wb_we_sel_result", got, expv);
            if (v.exp_we) check("rf_wr_data", rf_wr_data, v.exp_res);
            check("alu_instruct_held", alu_instruct, v.ins);
            check("alu_address_held", alu_address, v.adr);
         end
      end
      start = 1'b0;
      check("done_seen", done_cnt, 1);
      check("busy_cycles", busy_cyc, v.lat);
      check("we_pulses", we_cnt, 32'(v.exp_we));
      @(negedge clk);
      check("idle_after_wb", {busy, done, rf_we, rf_wr_sel}, 7'd0);
      if (poke) begin
         extra_done = 0;
         repeat (5) begin
            @(negedge clk);
            if (done) extra_done++;
         end
         check("poke_no_extra_done", extra_done, 0);
      end
   endtask

   initial begin
      int dcnt, d1_cyc, d2_cyc, wcnt;
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;

      vecs[0] = '{8'h01, 8'h2A, 8'h05, 8'h03, 1'b1, 4'b0100, 8'h08, 3};
      vecs[1] = '{8'h02, 8'h70, 8'h10, 8'h01, 1'b1, 4'b0001, 8'h0F, 3};
      vecs[2] = '{8'h03, 8'hB9, 8'h07, 8'h06, 1'b1, 4'b0010, 8'h2A, 5};
      vecs[3] = '{8'h04, 8'hC7, 8'h64, 8'h05, 1'b1, 4'b1000, 8'h14, 5};
      vecs[4] = '{8'h05, 8'h1F, 8'hF0, 8'h3C, 1'b1, 4'b1000, 8'h30, 3};
      vecs[5] = '{8'h06, 8'h4D, 8'hA0, 8'h05, 1'b1, 4'b0010, 8'hA5, 3};
      vecs[6] = '{8'h07, 8'h94, 8'hFF, 8'h0F, 1'b1, 4'b0001, 8'hF0, 3};
      vecs[7] = '{8'h01, 8'h2A, 8'hFF, 8'h02, 1'b1, 4'b0100, 8'h01, 3};
      vecs[8] = '{8'h00, 8'h2A, 8'h11, 8'h22, 1'b0, 4'b0000, 8'h01, 3};
      vecs[9] = '{8'h13, 8'hB9, 8'h10, 8'h10, 1'b1, 4'b0010, 8'h00, 5};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_ctrl", {busy, done, rf_we, rf_wr_sel}, 7'd0);
      check("rst_alu", {alu_instruct, alu_address, alu_data1, alu_data2}, 32'd0);
      check("rst_rd_addr", {rf_rd_addr1, rf_rd_addr2}, 6'd0);
      check("rst_wr", {rf_wr_data, result}, 16'd0);
      check("rst_state", fsm_state, 2'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_instr(vecs[i], 1'b0);

      // start pokes during READ/EXEC of an ADD
      run_instr(vecs[0], 1'b1);

      // start held high re-accepts one cycle after WB
      rf[1] = 8'h05; rf[2] = 8'h03;
      @(negedge clk);
      start = 1'b1; instruct = 8'h01; address = 8'h2A;
      dcnt = 0; d1_cyc = 0; d2_cyc = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 4) check("held_idle_gap", busy, 1'b0);
         if (c == 5) start = 1'b0;
         if (done) begin
            dcnt++;
            if (dcnt == 1) d1_cyc = c; else d2_cyc = c;
         end
      end
      check("held_done_count", dcnt, 2);
      check("held_first_done", d1_cyc, 3);
      check("held_second_done", d2_cyc, 7);

      // reset during EXEC of a DIV
      rf[6] = 8'h64; rf[1] = 8'h05;
      @(negedge clk);
      start = 1'b1; instruct = 8'h04; address = 8'hC7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("div_in_exec", fsm_state, 2'd2);
      rst = 1'b1;
      #1;
      check("abort_ctrl", {busy, done, rf_we, rf_wr_sel}, 7'd0);
      check("abort_alu", {alu_instruct, alu_data1, alu_data2}, 24'd0);
      check("abort_wr", {rf_wr_data, result}, 16'd0);
      check("abort_state", fsm_state, 2'd0);
      wcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (rf_we || done) wcnt++;
      end
      check("abort_no_wb", wcnt, 0);
      rst = 1'b0;
      run_instr(vecs[3], 1'b0);

`ifdef ALU_EXEC_FLAGS_EN
      run_instr('{8'h02, 8'h70, 8'h44, 8'h44, 1'b1, 4'b0001, 8'h00, 3}, 1'b0);
      check("flags_zero", {flag_z, flag_n}, 2'b10);
      run_instr('{8'h02, 8'h70, 8'h00, 8'h01, 1'b1, 4'b0001, 8'hFF, 3}, 1'b0);
      check("flags_neg", {flag_z, flag_n}, 2'b01);
      run_instr('{8'h00, 8'h70, 8'h00, 8'h00, 1'b0, 4'b0000, 8'hFF, 3}, 1'b0);
      check("flags_nop_hold", {flag_z, flag_n}, 2'b01);
`endif

      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter MULDIV_WAIT, default 2, extra EXEC cycles inserted for multiply/divide opcodes (range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to execute one instruction; sampled only in IDLE.
REQ-005 instruct  input  8  instruction byte; bits [3:0] opcode, [4] unsigned modifier.
REQ-006 address  input  8  operand byte; [7:5] source reg 1, [4:2] source reg 2, [1:0] destination reg.
REQ-007 busy  output  1  high while an accepted instruction is in flight.
REQ-008 done  output  1  one-cycle pulse when the instruction retires.
REQ-009 rf_rd_addr1, rf_rd_addr2  output  3 each  register-file read addresses.
REQ-010 rf_rd_data1, rf_rd_data2  input  8 each  register-file read data, combinational from addresses.
REQ-011 alu_instruct, alu_address, alu_data1, alu_data2  output  8 each  registered ALU operands/controls.
REQ-012 alu_ans  input  8  combinational ALU result.
REQ-013 rf_we  output  1  register-file write strobe, one cycle.
REQ-014 rf_wr_sel  output  4  one-hot destination select decoded from address[1:0].
REQ-015 rf_wr_data, result  output  8 each  write-back data / last retired result.

Function
REQ-016 FSM states IDLE, READ, EXEC, WB; encoding free.
REQ-017 IDLE: start=1 at edge N latches instruct/address, drives rf_rd_addr1/2 from latched address, moves to READ.
REQ-018 READ (one cycle): alu_data1/alu_data2 capture rf_rd_data1/2, alu_instruct/alu_address capture latched bytes; next EXEC.
REQ-019 EXEC: one cycle for all opcodes except 3 (mul) and 4 (div), which stay 1+MULDIV_WAIT cycles via down-counter.
REQ-020 WB (one cycle): rf_wr_data=result=alu_ans sampled at end of EXEC, rf_we=1, done=1; next IDLE.
REQ-021 Latency: start at edge N -> done/rf_we high in cycle N+3 (N+3+MULDIV_WAIT for mul/div).
REQ-022 Opcode 0 (NOP): full sequence, done pulses, rf_we stays 0, result unchanged.
REQ-023 rf_wr_sel: 00->0001, 01->0010, 10->0100, 11->1000; all zero outside WB.
REQ-024 busy=1 in READ, EXEC, WB; 0 in IDLE.
REQ-025 start while busy is ignored and not queued; start held high re-accepts in the IDLE cycle after WB.
REQ-026 Inputs instruct/address may change after acceptance without affecting the in-flight instruction.

Reset
REQ-027 rst asserted at any time forces IDLE immediately; busy, done, rf_we = 0; rf_wr_sel = 0.
REQ-028 Reset values: alu_* = 8'h00, rf_rd_addr* = 0, rf_wr_data = 8'h00, result = 8'h00, wait counter = 0.
REQ-029 Reset mid-instruction aborts it: no write-back, no done pulse.

Configuration
REQ-030 Macro ALU_EXEC_FLAGS_EN: when defined, adds outputs flag_z and flag_n (1 bit each), updated in WB from alu_ans (z = ans==0, n = ans[7]), unchanged on NOP, reset to 0; when undefined, ports and logic are absent and all other behaviour is identical.

Verification
REQ-031 rf r1=8'h05, r2=8'h03; start, instruct=8'h01, address=8'b001_010_10 -> done in cycle N+3, rf_we=1, rf_wr_sel=0100, rf_wr_data=8'h08 (ALU model).
REQ-032 MULDIV_WAIT=2, instruct=8'h03 -> busy 5 cycles, done at N+5, exactly one rf_we pulse.
REQ-033 start pulsed in READ and EXEC of an ADD -> ignored, exactly one done, busy drops after WB.
REQ-034 rst asserted during EXEC of a DIV -> outputs at reset values same cycle, no rf_we, next start executes normally.
REQ-035 instruct=8'h00 -> done at N+3, rf_we=0, result unchanged.
REQ-036 ALU_EXEC_FLAGS_EN defined, SUB with r1=r2=8'h44 -> flag_z=1, flag_n=0 after WB; then r1=8'h00, r2=8'h01 -> flag_z=0, flag_n=1.
